// File: rtl/vermi_interconnect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : vermi_interconnect                                      |
// | Description : Single-initiator Vermibus interconnect. Decodes         |
// |               address[31:24] onto N_SLAVES targets, broadcasts the    |
// |               request, returns the selected response, ORs masked      |
// |               interrupts, and keeps a sticky error for unmapped       |
// |               accesses. Optional BUSY-wait timeout is built when      |
// |               VERMI_INTERCONNECT_TIMEOUT_EN is defined.               |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module vermi_interconnect #(
  parameter int                         N_SLAVES       = 3,
  parameter logic [N_SLAVES-1:0][7:0]   SLAVE_PREFIX   = {8'h81, 8'h80, 8'h00},
  parameter logic [N_SLAVES-1:0]        IRQ_MASK       = '1,
  parameter logic [7:0]                 TIMEOUT_CYCLES = 8'd255
) (
  input  logic                    clk,
  input  logic                    reset,
  // initiator side
  input  logic                    m_valid,
  output logic                    m_ready,
  output logic                    m_irq,
  input  logic [31:0]             m_address,
  input  logic [31:0]             m_wdata,
  input  logic [3:0]              m_wstrobe,
  output logic [31:0]             m_rdata,
  // target side
  output logic [N_SLAVES-1:0]     s_valid,
  input  logic [N_SLAVES-1:0]     s_ready,
  input  logic [N_SLAVES-1:0]     s_irq,
  output logic [N_SLAVES*32-1:0]  s_address,
  output logic [N_SLAVES*32-1:0]  s_wdata,
  output logic [N_SLAVES*4-1:0]   s_wstrobe,
  input  logic [N_SLAVES*32-1:0]  s_rdata,
  // error reporting
  output logic                    err,
  output logic [31:0]             err_address,
  input  logic                    err_clear
);

  localparam int c_SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_SEL_W-1:0]   r_sel_q;
  logic [c_SEL_W-1:0]   w_dec_sel;
  logic                 w_hit;
  logic [c_SEL_W-1:0]   w_sel;
  logic [N_SLAVES-1:0]  w_sel_onehot;
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic                 w_latch;
  logic                 w_new_err;

`ifdef VERMI_INTERCONNECT_TIMEOUT_EN
  logic [7:0]           r_wait_cnt;
`endif

  // Request fields go to every target; only s_valid is steered
  genvar g;
  generate
    for (g = 0; g < N_SLAVES; g++) begin : g_bcast
      assign s_address[g*32 +: 32] = m_address;
      assign s_wdata[g*32 +: 32]   = m_wdata;
      assign s_wstrobe[g*4 +: 4]   = m_wstrobe;
    end
  endgenerate

  // Interrupt aggregation through the static mask
  assign m_irq = |(s_irq & IRQ_MASK);

  // Prefix decode; scanning downward lets the lowest matching index win
  always_comb begin
    w_hit     = 1'b0;
    w_dec_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (m_address[31:24] == SLAVE_PREFIX[i]) begin
        w_hit     = 1'b1;
        w_dec_sel = c_SEL_W'(i);
      end
    end
  end

  // Live decode while idle, latched selection while a transfer is stalled
  assign w_sel = (r_state == ST_BUSY) ? r_sel_q : w_dec_sel;

  // Response mux and one-hot valid for the current selection
  always_comb begin
    w_sel_onehot = '0;
    w_sel_ready  = 1'b0;
    w_sel_rdata  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_sel == c_SEL_W'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_ready     = s_ready[i];
        w_sel_rdata     = s_rdata[i*32 +: 32];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and initiator/target handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    m_ready     = 1'b0;
    m_rdata     = '0;
    s_valid     = '0;
    w_latch     = 1'b0;
    w_new_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) begin
          if (w_hit) begin
            s_valid = w_sel_onehot;
            m_ready = w_sel_ready;
            m_rdata = w_sel_rdata;
            if (!w_sel_ready) begin
              w_latch     = 1'b1;
              w_state_nxt = ST_BUSY;
            end
          end else begin
            // unmapped: complete immediately with zero data and flag it
            m_ready   = 1'b1;
            w_new_err = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (m_valid) begin
          s_valid = w_sel_onehot;
          m_ready = w_sel_ready;
          m_rdata = w_sel_rdata;
        end
        if (w_sel_ready) begin
          w_state_nxt = ST_IDLE;
        end
`ifdef VERMI_INTERCONNECT_TIMEOUT_EN
        else if (r_wait_cnt == TIMEOUT_CYCLES) begin
          // target never answered: force an all-ones error completion
          w_state_nxt = ST_IDLE;
          w_new_err   = 1'b1;
          if (m_valid) begin
            m_ready = 1'b1;
            m_rdata = 32'hFFFF_FFFF;
          end
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the target index when a transfer has to wait
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_sel_q <= '0;
    else if (w_latch) r_sel_q <= w_dec_sel;
  end

`ifdef VERMI_INTERCONNECT_TIMEOUT_EN
  // Wait counter: starts at 1 on entry to BUSY, counts stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_wait_cnt <= '0;
    else if (w_latch)                              r_wait_cnt <= 8'd1;
    else if (r_state == ST_BUSY && !w_sel_ready)   r_wait_cnt <= r_wait_cnt + 8'd1;
  end
`endif

  // Sticky error: keeps the first faulting address until cleared; a new
  // error in the clearing cycle restarts capture with its own address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err         <= 1'b0;
      err_address <= '0;
    end else if (w_new_err) begin
      err <= 1'b1;
      if (!err || err_clear) err_address <= m_address;
    end else if (err_clear) begin
      err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/vermi_interconnect.md
VERMI_INTERCONNECT -- requirements
Module: vermi_interconnect

Interface
REQ-001 Parameter N_SLAVES, default 3: number of target ports, range 1..16.
REQ-002 Parameter SLAVE_PREFIX, default {8'h81, 8'h80, 8'h00}: packed N_SLAVES x 8-bit array; entry i is the address[31:24] prefix of slave i.
REQ-003 Parameter IRQ_MASK, default all ones: N_SLAVES-bit mask; bit i enables s_irq[i] onto m_irq.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: 8-bit, 1..255; maximum wait cycles before a forced error response.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Ports m_valid/m_ready/m_irq, input/output/output, 1 each: initiator-side Vermibus handshake and interrupt.
REQ-008 Ports m_address/m_wdata/m_rdata, input/input/output, 32 each; m_wstrobe, input, 4: initiator-side request and response data.
REQ-009 Ports s_valid/s_ready/s_irq, output/input/input, N_SLAVES each: per-target handshake and interrupt.
REQ-010 Ports s_address/s_wdata/s_rdata, output/output/input, N_SLAVES*32 each; s_wstrobe, output, N_SLAVES*4: per-target request/response, packed with slave i at slice [i*W +: W].
REQ-011 Ports err, output, 1; err_address, output, 32; err_clear, input, 1: sticky error flag, captured faulting address, and clear strobe.

Function
REQ-012 Decode SHALL match m_address[31:24] against SLAVE_PREFIX; when several entries match, the lowest index wins.
REQ-013 s_address, s_wstrobe and s_wdata SHALL be broadcast to all slaves; only the selected slave sees s_valid[i]=1.
REQ-014 FSM states: IDLE, BUSY. Reset state: IDLE.
REQ-015 IDLE: the selection is combinational from m_address, so s_valid[sel] = m_valid with zero added latency.
REQ-016 IDLE + m_valid + mapped + s_ready[sel]=1 -> same-cycle completion; the FSM stays in IDLE.
REQ-017 IDLE + m_valid + mapped + s_ready[sel]=0 -> latch sel into sel_q, load wait counter with 1, go to BUSY.
REQ-018 BUSY: the selection comes from sel_q; m_ready = s_ready[sel_q], m_rdata = s_rdata slice sel_q; on s_ready the FSM returns to IDLE.
REQ-019 Unmapped address with m_valid: m_ready=1 and m_rdata=0 in the same cycle, no s_valid asserted, err set, err_address <= m_address; the FSM stays in IDLE.
REQ-020 When m_valid=0, m_ready=0, m_rdata=0 and all s_valid=0.
REQ-021 m_irq = OR over i of (s_irq[i] & IRQ_MASK[i]), combinational.
REQ-022 Initiator rule: once m_valid rises, the request is held stable until m_ready; the block does not check this.
REQ-023 err_clear=1 clears err on the next edge; a new error in the same cycle wins (err stays 1, err_address updated).
REQ-024 While err=1, err_address SHALL hold the first faulting address; later errors do not overwrite it.

Reset
REQ-025 Reset assertion SHALL, asynchronously: set the FSM to IDLE; clear sel_q, the wait counter, err and err_address to 0.
REQ-026 Reset asserted mid-BUSY SHALL abandon the transaction with no m_ready pulse; combinational outputs then follow REQ-015/REQ-020 from IDLE.

Configuration
REQ-027 Macro VERMI_INTERCONNECT_TIMEOUT_EN.
- Defined: in BUSY, the wait counter increments each cycle that s_ready[sel_q]=0. When it equals TIMEOUT_CYCLES, the block forces m_ready=1 and m_rdata=32'hFFFF_FFFF, sets err, captures err_address (subject to REQ-024) and returns to IDLE. s_ready arriving in the same cycle takes priority, giving a normal completion with no error.
- Undefined: no counter logic; BUSY waits indefinitely for s_ready.

Verification
REQ-028 Write 0x0000_0010, wdata 0x1234_5678, RAM ready same cycle -> s_valid=3'b001, m_ready in the same cycle, FSM stays IDLE.
REQ-029 Read 0x8000_0004, timer ready after 3 cycles with rdata 0x0000_00AA -> FSM in BUSY for 3 cycles; m_ready and m_rdata=0xAA in cycle 4.
REQ-030 Read 0x4200_0000 (unmapped) -> m_ready=1 and m_rdata=0 in the same cycle; err=1, err_address=0x4200_0000. A second unmapped access to 0x4300_0000 leaves err_address unchanged.
REQ-031 With TIMEOUT_EN and TIMEOUT_CYCLES=4, read UART 0x8100_0000 with s_ready held 0 -> m_ready=1 with rdata 0xFFFF_FFFF four cycles after entry to BUSY, err=1. Without the macro, m_ready stays 0 for at least 300 cycles.
REQ-032 s_irq=3'b110 with IRQ_MASK=3'b011 -> m_irq=1. Then s_irq=3'b100 -> m_irq=0.
REQ-033 Assert reset in the second BUSY cycle of a timer read -> FSM IDLE immediately, no m_ready pulse, err=0. After reset release, a new RAM access completes normally.
